// File: rtl/db9md_joy_scanner.sv
// Two-player DB9 / Mega Drive pad scanner: walks the SELECT line through eight
// phases per player behind the splitter and publishes active-high button words.
module db9md_joy_scanner #(
  parameter int PHASE_CYC  = 512,
  parameter int SETTLE_CYC = 256,
  parameter int FRAME_CYC  = 100000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [5:0]  joy_in,
  output logic        joy_split,
  output logic        joy_mdsel,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic [1:0]  pad_type1,
  output logic [1:0]  pad_type2,
  output logic        scan_done
);

  // state   | meaning
  // WAIT    | idle gap between scan pairs, lets 6-button pads reset their counter
  // SETTLE  | splitter just switched, wait before driving phases
  // PH0-PH7 | SELECT phases, even = high, odd = low; pins sampled on last cycle
  // COMMIT  | publish current player's word and type, switch player
  typedef enum logic [3:0] {
    S_WAIT, S_SETTLE, S_PH0, S_PH1, S_PH2, S_PH3,
    S_PH4, S_PH5, S_PH6, S_PH7, S_COMMIT
  } state_t;

  localparam int MAX_AB  = (FRAME_CYC > SETTLE_CYC) ? FRAME_CYC : SETTLE_CYC;
  localparam int MAX_CYC = (MAX_AB > PHASE_CYC) ? MAX_AB : PHASE_CYC;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, term_cnt;
  logic               phase_end;
  logic               mdsel_nxt;
  logic [5:0]         sync1, sync2;
  logic [5:0]         pins;
  logic [11:0]        cap;
  logic               md_det, six_det;
  logic [1:0]         player;
  logic [15:0]        commit_word;
  logic [1:0]         commit_type;

  assign pins = ~sync2;

  always_comb begin
    term_cnt  = CNT_W'(PHASE_CYC - 1);
    state_nxt = state;
    case (state)
      S_WAIT:   term_cnt = CNT_W'(FRAME_CYC - 1);
      S_SETTLE: term_cnt = CNT_W'(SETTLE_CYC - 1);
      S_COMMIT: term_cnt = '0;
      default:  term_cnt = CNT_W'(PHASE_CYC - 1);
    endcase
    phase_end = (cnt == term_cnt);
    if (phase_end) begin
      case (state)
        S_WAIT:   state_nxt = S_SETTLE;
        S_SETTLE: state_nxt = S_PH0;
        S_PH0:    state_nxt = S_PH1;
        S_PH1:    state_nxt = S_PH2;
        S_PH2:    state_nxt = S_PH3;
        S_PH3:    state_nxt = S_PH4;
        S_PH4:    state_nxt = S_PH5;
        S_PH5:    state_nxt = S_PH6;
        S_PH6:    state_nxt = S_PH7;
        S_PH7:    state_nxt = S_COMMIT;
        S_COMMIT: state_nxt = (player == 2'd1) ? S_SETTLE : S_WAIT;
        default:  state_nxt = S_WAIT;
      endcase
    end
    mdsel_nxt = !(state_nxt inside {S_PH1, S_PH3, S_PH5, S_PH7});
  end

  // Pad type and word are derived only from what the detection phases saw.
  always_comb begin
    commit_word = 16'd0;
    commit_type = 2'd0;
    if (!md_det) begin
      commit_word = {10'd0, cap[5:0]};
    end else if (!six_det) begin
      commit_word = {8'd0, cap[7:0]};
      commit_type = 2'd1;
    end else begin
      commit_word = {4'd0, cap};
      commit_type = 2'd2;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= S_WAIT;
      cnt       <= '0;
      sync1     <= '1;
      sync2     <= '1;
      cap       <= '0;
      md_det    <= 1'b0;
      six_det   <= 1'b0;
      player    <= 2'd1;
      joy_split <= 1'b1;
      joy_mdsel <= 1'b1;
      joystick1 <= '0;
      joystick2 <= '0;
      pad_type1 <= '0;
      pad_type2 <= '0;
      scan_done <= 1'b0;
    end else begin
      sync1     <= joy_in;
      sync2     <= sync1;
      state     <= state_nxt;
      cnt       <= phase_end ? '0 : cnt + CNT_W'(1);
      joy_mdsel <= mdsel_nxt;
      scan_done <= 1'b0;
      if (phase_end) begin
        case (state)
          S_PH0: begin
            cap[0] <= pins[3];
            cap[1] <= pins[2];
            cap[2] <= pins[1];
            cap[3] <= pins[0];
            cap[4] <= pins[4];
            cap[5] <= pins[5];
          end
          S_PH1: begin
            cap[6] <= pins[4];
            cap[7] <= pins[5];
            md_det <= pins[2] & pins[3];
          end
          S_PH3: six_det <= &pins[3:0];
          S_PH5: six_det <= six_det | (&pins[3:0]);
          S_PH6: begin
            cap[8]  <= pins[0];
            cap[10] <= pins[1];
            cap[9]  <= pins[2];
            cap[11] <= pins[3];
          end
          S_COMMIT: begin
            scan_done <= 1'b1;
            if (player == 2'd1) begin
              joystick1 <= commit_word;
              pad_type1 <= commit_type;
              joy_split <= 1'b0;
              player    <= 2'd2;
            end else begin
              joystick2 <= commit_word;
              pad_type2 <= commit_type;
              joy_split <= 1'b1;
              player    <= 2'd1;
            end
          end
          default: ;
        endcase
        // Per-scan captures start clean for every player.
        if (state_nxt == S_SETTLE) begin
          cap     <= '0;
          md_det  <= 1'b0;
          six_det <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/db9md_joy_scanner.md
Name: db9md_joy_scanner

Overview:
- Upstream input stage for the core's SNAC joystick path.
- Drives the DB9 splitter select (joy_split) and the Mega Drive SELECT line (joy_mdsel) through the user port, and runs the MD 3/6-button read protocol for two players in turn.
- Publishes two active-high 16-bit button words.
- The top-level joystick mux, joy_raw and the OSD-combo logic consume those words.

Parameters:
- PHASE_CYC, 512: clk_sys cycles per SELECT phase (about 10 us at 50 MHz).
- SETTLE_CYC, 256: cycles after a joy_split change before phase 0 starts.
- FRAME_CYC, 100000: idle cycles between scan pairs. Must exceed 1.5 ms so the 6-button pad counter resets.

Ports:
- clk_sys, in, 1: system clock; the only clock.
- reset, in, 1: synchronous, active-high reset.
- joy_in, in, 6: raw pins, active low. [0] up, [1] down, [2] left, [3] right, [4] pin6 (A/B), [5] pin9 (Start/C).
- joy_split, out, 1: splitter select. 1 = player 1, 0 = player 2.
- joy_mdsel, out, 1: MD SELECT line.
- joystick1, out, 16: player 1 buttons, active high.
- joystick2, out, 16: player 2 buttons, active high.
- pad_type1, out, 2: player 1 pad type. 0 = none/Atari, 1 = MD 3-button, 2 = MD 6-button.
- pad_type2, out, 2: player 2 pad type, same encoding.
- scan_done, out, 1: one-cycle pulse when a player's commit happens.

Behaviour:
- Button word bit map: [0] R, [1] L, [2] D, [3] U, [4] B, [5] C, [6] A, [7] Start, [8] Z, [9] X, [10] Y, [11] Mode. Bits [15:12] are always 0.
- joy_in passes through a 2-flop synchroniser. All sampling uses the synchronised value, inverted to active high.
- Reset values: joy_split=1, joy_mdsel=1, joystick1/2=0, pad_type1/2=0, scan_done=0, FSM=WAIT, all counters 0, player=1.
- Reset asserted mid-scan: the scan is aborted and nothing partial is committed. Everything returns to the reset values on the next edge. After deassert, the first scan starts after a full FRAME_CYC.
- FSM states: WAIT, SETTLE, PH0..PH7, COMMIT.
- WAIT: joy_split=1, mdsel=1. Lasts FRAME_CYC cycles, then goes to SETTLE.
- SETTLE: lasts SETTLE_CYC cycles with mdsel=1, then goes to PH0.
- PHn: lasts PHASE_CYC cycles. mdsel=1 for even n, 0 for odd n. Pins are sampled on the last cycle of the phase (count == PHASE_CYC-1).
  - PH0: capture U, D, L, R, B (pin6), C (pin9).
  - PH1: capture A (pin6) and Start (pin9). Set md_det = L & R (both pins low).
  - PH3: set six_det = U & D & L & R (all four low). PH5 applies the same test and ORs into six_det.
  - PH6: capture Z=U-pin, Y=D-pin, X=L-pin, Mode=R-pin.
  - PH7: no capture.
- COMMIT: lasts one cycle. Writes the current player's word and pad_type atomically and pulses scan_done.
  - md_det=0: type 0, word = {A=0, Start=0, XYZ/Mode=0, PH0 bits}.
  - md_det=1 and six_det=0: type 1, XYZ/Mode forced to 0.
  - md_det=1 and six_det=1: type 2, full word.
  - Then, if player==1: set joy_split=0, player=2, go to SETTLE. Otherwise: set joy_split=1, player=1, go to WAIT.
- Scan period: FRAME_CYC + 2*(SETTLE_CYC + 8*PHASE_CYC + 1) cycles.
- Output words are otherwise held stable between commits. The per-scan capture registers are cleared on entry to SETTLE.
- joy_mdsel and joy_split are registered, with no combinational path from joy_in.
- Counter widths are sized from the parameters. Each counter wraps to 0 at its terminal count.

Test Plan:
- Atari stick on P1, all pins high except pin6 and up low -> after the first P1 commit: joystick1=16'h0018, pad_type1=0, joystick2=0.
- MD 3-button model on P2, Start+A pressed -> joystick2=16'h00C0, pad_type2=1. joy_split is 0 during the P2 phases and mdsel toggles exactly 8 times.
- MD 6-button model on P1, X+Mode+Right pressed -> joystick1=16'h0A01, pad_type1=2. The model's counter reset during WAIT is honoured on the next scan: same result, with no phase slip.
- No pad (joy_in=6'h3F) -> both words 0 and both types 0. scan_done pulses twice per scan period, with period = FRAME_CYC+2*(SETTLE_CYC+8*PHASE_CYC+1).
- Assert reset for 1 cycle during PH4 of P2 after a valid prior commit -> next edge gives joystick1/2=0, split=1, mdsel=1. No scan_done until the WAIT+P1 scan completes.
- P1 pad held with B pressed, P2 changing buttons mid-scan -> joystick1 stays constant and joystick2 changes only on the cycle scan_done pulses for player 2.
